// File: rtl/lpc_sequencer.sv
// lpc_sequencer: runs autocorr -> lag window -> levinson and muxes their shared memory port.
// Define LPC_SEQ_TIMEOUT_EN to abort a stage that runs TIMEOUT cycles without its done pulse.
module lpc_sequencer #(
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        testMode,
    input  logic [2:0]  stageDone,
    input  logic [2:0]  reqWrite,
    input  logic [32:0] reqAddr,
    input  logic [95:0] reqData,
    input  logic        testWriteEnable,
    input  logic [10:0] testWriteRequested,
    input  logic [31:0] testWriteOut,
    input  logic [10:0] testReadRequested,
    output logic [2:0]  stageStart,
    output logic        memWrite,
    output logic [10:0] memAddr,
    output logic [31:0] memDataOut,
    output logic [1:0]  stage,
    output logic        busy,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, RUN_AC, RUN_LAG, RUN_LEV, DONE, ERROR} state_t;

    state_t     state_q, state_d;
    logic [2:0] stage_start_q, stage_start_d;
    logic       expired, run_ac, run_lag, run_lev, test_sel;

`ifdef LPC_SEQ_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    assign expired = cnt_q == 16'(TIMEOUT - 1);
    assign cnt_d   = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
    assign error   = state_q == ERROR;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign expired = 1'b0;
    assign error   = 1'b0;
`endif

    // stageDone is tested before expiry so a done in the last allowed cycle wins
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN_AC : IDLE;
            RUN_AC:  state_d = stageDone[0] ? RUN_LAG : expired ? ERROR : RUN_AC;
            RUN_LAG: state_d = stageDone[1] ? RUN_LEV : expired ? ERROR : RUN_LAG;
            RUN_LEV: state_d = stageDone[2] ? DONE : expired ? ERROR : RUN_LEV;
            DONE:    state_d = IDLE;
            ERROR:   state_d = start ? RUN_AC : ERROR;
            default: state_d = IDLE;
        endcase
        stage_start_d = {state_d == RUN_LEV && state_q != RUN_LEV,
                         state_d == RUN_LAG && state_q != RUN_LAG,
                         state_d == RUN_AC  && state_q != RUN_AC};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            stage_start_q <= '0;
        end else begin
            state_q       <= state_d;
            stage_start_q <= stage_start_d;
        end
    end

    assign run_ac     = state_q == RUN_AC;
    assign run_lag    = state_q == RUN_LAG;
    assign run_lev    = state_q == RUN_LEV;
    assign busy       = run_ac | run_lag | run_lev;
    assign done       = state_q == DONE;
    assign stage      = run_ac ? 2'd0 : run_lag ? 2'd1 : run_lev ? 2'd2 : 2'd3;
    assign stageStart = stage_start_q;
    assign test_sel   = testMode & ~busy;

    assign memWrite   = run_lev ? reqWrite[2] : run_lag ? reqWrite[1] : run_ac ? reqWrite[0] :
                        test_sel & testWriteEnable;
    assign memAddr    = run_lev ? reqAddr[32:22] : run_lag ? reqAddr[21:11] : run_ac ? reqAddr[10:0] :
                        !test_sel ? 11'd0 : testWriteEnable ? testWriteRequested : testReadRequested;
    assign memDataOut = run_lev ? reqData[95:64] : run_lag ? reqData[63:32] : run_ac ? reqData[31:0] :
                        test_sel ? testWriteOut : 32'd0;
endmodule

// File: tb/tb_lpc_sequencer.sv
// tb_lpc_sequencer: directed runs; expected stageStart/done events are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_lpc_sequencer;
    logic        clk = 0, reset = 0, start = 0, testMode = 0, testWriteEnable = 0;
    logic [2:0]  stageDone = 0, reqWrite = 0;
    logic [32:0] reqAddr = 0;
    logic [95:0] reqData = 0;
    logic [10:0] testWriteRequested = 0, testReadRequested = 0;
    logic [31:0] testWriteOut = 0;
    logic [2:0]  stageStart;
    logic        memWrite, busy, done, error;
    logic [10:0] memAddr;
    logic [31:0] memDataOut;
    logic [1:0]  stage;

    typedef struct {logic [2:0] ss; logic dn; int cyc;} ev_t;
    ev_t q[$];
    int checks = 0, failures = 0, cyc = 0, busy_cnt = 0;

    lpc_sequencer #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .testMode(testMode), .stageDone(stageDone),
        .reqWrite(reqWrite), .reqAddr(reqAddr), .reqData(reqData),
        .testWriteEnable(testWriteEnable), .testWriteRequested(testWriteRequested),
        .testWriteOut(testWriteOut), .testReadRequested(testReadRequested),
        .stageStart(stageStart), .memWrite(memWrite), .memAddr(memAddr), .memDataOut(memDataOut),
        .stage(stage), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic void push(logic [2:0] ss, logic dn, int c);
        ev_t e;
        e.ss = ss; e.dn = dn; e.cyc = c;
        q.push_back(e);
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (stageStart != 3'b000 || done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event stageStart=%b done=%b at cycle %0d", stageStart, done, cyc);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("ev_stageStart", 32'(stageStart), 32'(e.ss));
                chk("ev_done", 32'(done), 32'(e.dn));
                chk("ev_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic run(int lat, bit mux, bit noise, bit abort);
        int c0;
        busy_cnt = 0;
        start = 1; tick(1); start = 0;
        c0 = cyc;
        push(3'b001, 0, c0);
        chk("ac_stage", 32'(stage), 0);
        chk("ac_busy", 32'(busy), 1);
        for (int i = 0; i < lat; i++) begin
            stageDone = (noise && i == 1) ? 3'b110 : 3'b000;
            start = noise && i == 1;
            tick(1);
            if (noise && i == 1) chk("noise_stage", 32'(stage), 0);
        end
        start = 0;
        stageDone = 3'b001; push(3'b010, 0, c0 + lat + 1); tick(1); stageDone = 0;
        chk("lag_stage", 32'(stage), 1);
        if (mux) begin
            reqWrite = 3'b010;
            reqAddr = {11'h3C3, 11'h05A, 11'h111};
            reqData = {32'h55555555, 32'hDEADBEEF, 32'h11111111};
            #1;
            chk("run_memWrite", 32'(memWrite), 1);
            chk("run_memAddr", 32'(memAddr), 32'h05A);
            chk("run_memDataOut", memDataOut, 32'hDEADBEEF);
            reqWrite = 0; reqAddr = 0; reqData = 0;
        end
        repeat (lat) tick(1);
        stageDone = 3'b010; push(3'b100, 0, c0 + 2 * lat + 2); tick(1); stageDone = 0;
        chk("lev_stage", 32'(stage), 2);
        if (abort) begin
            tick(1);
            #2 reset = 0;
            #1;
            chk("abort_busy", 32'(busy), 0);
            chk("abort_stage", 32'(stage), 3);
            chk("abort_stageStart", 32'(stageStart), 0);
            @(negedge clk) reset = 1;
            tick(3);
            chk("abort_idle_stage", 32'(stage), 3);
            return;
        end
        repeat (lat) tick(1);
        stageDone = 3'b100; push(3'b000, 1, c0 + 3 * lat + 3); tick(1); stageDone = 0;
        chk("done_stage", 32'(stage), 3);
        chk("done_busy", 32'(busy), 0);
        tick(1);
        chk("busy_cycles", busy_cnt, 3 * (lat + 1));
    endtask

    initial begin
        int c;
        #3;
        chk("rst_stageStart", 32'(stageStart), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stage", 32'(stage), 3);
        chk("rst_memWrite", 32'(memWrite), 0);
        @(negedge clk) reset = 1;
        tick(2);

        testMode = 1; testReadRequested = 11'h123; testWriteRequested = 11'h7FF; testWriteOut = 32'hCAFEF00D;
        #1;
        chk("tm_rd_addr", 32'(memAddr), 32'h123);
        chk("tm_rd_write", 32'(memWrite), 0);
        chk("tm_rd_data", memDataOut, 32'hCAFEF00D);
        testWriteEnable = 1; #1;
        chk("tm_wr_addr", 32'(memAddr), 32'h7FF);
        chk("tm_wr_write", 32'(memWrite), 1);
        testMode = 0; #1;
        chk("notm_addr", 32'(memAddr), 0);
        chk("notm_write", 32'(memWrite), 0);
        chk("notm_data", memDataOut, 0);
        testWriteEnable = 0; testReadRequested = 0; testWriteRequested = 0; testWriteOut = 0;
        tick(1);

        run(10, 0, 0, 0);
        run(10, 1, 1, 0);
        run(3, 0, 0, 1);
        run(0, 0, 0, 0);

        start = 1; tick(1); start = 0;
        c = cyc;
        push(3'b001, 0, c);
        stageDone = 3'b001; push(3'b010, 0, c + 1); tick(1); stageDone = 0;
`ifdef LPC_SEQ_TIMEOUT_EN
        tick(15);
        chk("to_before_error", 32'(error), 0);
        chk("to_before_busy", 32'(busy), 1);
        tick(1);
        chk("to_error", 32'(error), 1);
        chk("to_stage", 32'(stage), 3);
        chk("to_busy", 32'(busy), 0);
        tick(3);
        chk("to_error_held", 32'(error), 1);
        start = 1; push(3'b001, 0, cyc + 1); tick(1); start = 0;
        chk("to_restart_error", 32'(error), 0);
        chk("to_restart_stage", 32'(stage), 0);
        stageDone = 3'b001; push(3'b010, 0, cyc + 1); tick(1);
`else
        tick(20);
        chk("noto_error", 32'(error), 0);
        chk("noto_stage", 32'(stage), 1);
`endif
        stageDone = 3'b010; push(3'b100, 0, cyc + 1); tick(1);
        stageDone = 3'b100; push(3'b000, 1, cyc + 1); tick(1);
        stageDone = 0;
        tick(3);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lpc_sequencer.md
LPC_SEQUENCER -- requirements
Module: lpc_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 4096, meaning the maximum number of cycles a stage may run before it is aborted (used only with LPC_SEQ_TIMEOUT_EN).
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse requesting one analysis run
- testMode  in  1  when idle, grants the memory port to the test interface
- stageDone  in  3  done pulses: [0] autocorr, [1] lag_window, [2] levinson
- reqWrite  in  3  per-stage memory write enable
- reqAddr  in  33  per-stage memory address, 11 bits each, stage i at [11i+10:11i]
- reqData  in  96  per-stage write data, 32 bits each, stage i at [32i+31:32i]
- testWriteEnable  in  1  test write enable
- testWriteRequested  in  11  test write address
- testWriteOut  in  32  test write data
- testReadRequested  in  11  test read address
- stageStart  out  3  one-hot single-cycle start pulses to the stages
- memWrite  out  1  shared memory write enable
- memAddr  out  11  shared memory address
- memDataOut  out  32  shared memory write data
- stage  out  2  active stage: 0 = autocorr, 1 = lag window, 2 = levinson, 3 = none
- busy  out  1  high in the RUN_* states
- done  out  1  single-cycle run-complete pulse
- error  out  1  stage timeout flag

Function
REQ-003 The FSM SHALL have states IDLE, RUN_AC, RUN_LAG, RUN_LEV, DONE and ERROR.
REQ-004 In IDLE, a sampled start=1 SHALL move the FSM to RUN_AC on that edge; start SHALL be ignored in every other state except ERROR.
REQ-005 stageStart[i] SHALL be registered and high for exactly the first cycle of the corresponding RUN state; it SHALL be 0 at all other times.
REQ-006 In RUN_AC, stageDone[0]=1 SHALL move the FSM to RUN_LAG; in RUN_LAG, stageDone[1]=1 SHALL move it to RUN_LEV; in RUN_LEV, stageDone[2]=1 SHALL move it to DONE.
REQ-007 stageDone bits of stages that are not active SHALL be ignored.
REQ-008 DONE SHALL last one cycle, with done=1 in that cycle, and SHALL then return to IDLE.
REQ-009 The memory mux SHALL be combinational with zero latency.
- In RUN_x: memWrite = reqWrite[x], memAddr = reqAddr[x], memDataOut = reqData[x].
- In IDLE, DONE and ERROR with testMode=1: memWrite = testWriteEnable, memDataOut = testWriteOut, memAddr = testWriteRequested when testWriteEnable=1, otherwise testReadRequested.
- In all other cases: memWrite = 0, memAddr = 0, memDataOut = 0.
REQ-010 stage SHALL equal 3 in IDLE, DONE and ERROR; busy SHALL be 1 exactly in RUN_AC, RUN_LAG and RUN_LEV.
REQ-011 A stage that asserts done in its own start cycle SHALL be accepted, giving a minimum run of 4 cycles from start to the done pulse.

Reset
REQ-012 While reset=0, the FSM SHALL go to IDLE immediately, independent of clk, and the timeout counter SHALL be cleared.
REQ-013 Reset values SHALL be: stageStart=0, done=0, error=0, busy=0, stage=3, memWrite=0 (testMode=0).
REQ-014 Reset asserted mid-run SHALL abort the run with no done pulse; the first start after reset is released SHALL begin a fresh run at RUN_AC.

Configuration
REQ-015 With LPC_SEQ_TIMEOUT_EN defined:
- A 16-bit counter SHALL clear on entry to each RUN state and increment every cycle in that state.
- If the counter reaches TIMEOUT-1 without the matching stageDone, the FSM SHALL go to ERROR.
- In ERROR, error=1 is held; start=1 SHALL clear error and go to RUN_AC.
- If stageDone and the timeout occur in the same cycle, stageDone SHALL win.
REQ-016 Without LPC_SEQ_TIMEOUT_EN, the block SHALL have no counter, error SHALL be tied to 0, and ERROR SHALL be unreachable.

Verification
REQ-017 Start pulse, each stageDone returned 10 cycles after its stageStart -> stageStart pulses 001, 010, 100 in order, done exactly one cycle after stageDone[2], busy for 33 cycles.
REQ-018 In RUN_LAG, drive reqWrite=3'b010, reqAddr[21:11]=11'h05A, reqData[63:32]=32'hDEADBEEF -> memWrite=1, memAddr=11'h05A, memDataOut=32'hDEADBEEF in the same cycle.
REQ-019 In IDLE with testMode=1, testWriteEnable=0, testReadRequested=11'h123 -> memAddr=11'h123, memWrite=0; with testMode=0 -> memAddr=0.
REQ-020 stageDone=3'b110 asserted during RUN_AC, plus a start pulse mid-run -> no state change; run continues normally.
REQ-021 With LPC_SEQ_TIMEOUT_EN and TIMEOUT=16, withhold stageDone[1] -> ERROR after 16 cycles in RUN_LAG, error=1 held; a following start -> error=0 and stageStart=001.
REQ-022 Drive reset low during RUN_LEV -> immediate IDLE, busy=0, and no done pulse.
